// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
//   W      : operand/result width of the shared datapath (fixed at 3)
//   CNT_W  : width of the optional overflow counters (OVF_CNT_EN builds)
//   ADD/SUB: mode encodings on the m input
//   state_t: arbiter FSM states
//   op_t   : operation captured on acceptance (operands, mode, owner id)
package addsub_pkg;

  localparam int unsigned W     = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         id;
  } op_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Handshake bus between two operand requesters, the arbiter and the result consumer.
//   req0_*/req1_* : valid/ready request channels carrying a, b and mode m
//   resp_*        : valid/ready result channel (id, s, carry vector c, overflow v)
// Modports: slave = arbiter side, master = requester/consumer side.
interface addsub_arbiter_if;
  import addsub_pkg::*;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_m;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_m;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_s;
  logic [W-1:0] resp_c;
  logic         resp_v;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_m,
    input  req1_valid, req1_a, req1_b, req1_m,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_s, resp_c, resp_v
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_m,
    output req1_valid, req1_a, req1_b, req1_m,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_s, resp_c, resp_v
  );

endinterface

// File: rtl/addsub3_core.sv
// Combinational W-bit ripple adder-subtractor.
//   a, b : operands
//   m    : ADD (a+b) or SUB (a+~b+1, carry-in = m)
//   s    : result mod 2^W
//   c    : carry out of each bit position
//   v    : signed overflow, carry into MSB xor carry out of MSB
module addsub3_core
  import addsub_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic [W-1:0] c,
  output logic         v
);

  logic [W-1:0] bx;
  logic         cy;

  // Ripple chain; cy carries bit i's carry-out into bit i+1.
  always_comb begin
    bx = (m == ADD) ? b : ~b;
    cy = (m == SUB);
    s  = '0;
    c  = '0;
    for (int i = 0; i < int'(W); i++) begin
      s[i] = a[i] ^ bx[i] ^ cy;
      cy   = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
      c[i] = cy;
    end
  end

  assign v = c[W-1] ^ c[W-2];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub3_core between two requesters.
// A request is accepted in IDLE, computed in CALC and held in HOLD until the
// consumer takes it; handshake in cycle N gives resp_valid in cycle N+2.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : addsub_arbiter_if.slave (request and response channels)
//   ovf_cnt0/ovf_cnt1 : saturating per-requester overflow counts, present
//                       only when OVF_CNT_EN is defined
module addsub_arbiter
  import addsub_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_arbiter_if.slave      bus
`ifdef OVF_CNT_EN
  ,
  output logic [CNT_W-1:0]     ovf_cnt0,
  output logic [CNT_W-1:0]     ovf_cnt1
`endif
);

  state_t       state_q;
  state_t       state_d;
  logic         rr_q;
  op_t          op_q;
  logic         any_valid;
  logic         grant_id;
  logic         accept;
  logic [W-1:0] core_s;
  logic [W-1:0] core_c;
  logic         core_v;
  logic         resp_done;

  // Grant the lone valid requester, or the rr-preferred one on contention.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = CALC;
      CALC:    state_d = HOLD;
      HOLD:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs: readies only in IDLE, never while in reset.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    accept         = 1'b0;
    resp_done      = (state_q == HOLD) && bus.resp_ready;
    if (rst_n && (state_q == IDLE) && any_valid) begin
      accept         = 1'b1;
      bus.req0_ready = ~grant_id;
      bus.req1_ready = grant_id;
    end
  end

  addsub3_core u_core (
    .a (op_q.a),
    .b (op_q.b),
    .m (op_q.m),
    .s (core_s),
    .c (core_c),
    .v (core_v)
  );

  // Operand capture, registered response and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q           <= '0;
      rr_q           <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_s     <= '0;
      bus.resp_c     <= '0;
      bus.resp_v     <= 1'b0;
    end else begin
      if (accept) begin
        op_q.a  <= grant_id ? bus.req1_a : bus.req0_a;
        op_q.b  <= grant_id ? bus.req1_b : bus.req0_b;
        op_q.m  <= grant_id ? bus.req1_m : bus.req0_m;
        op_q.id <= grant_id;
      end
      if (state_q == CALC) begin
        bus.resp_valid <= 1'b1;
        bus.resp_id    <= op_q.id;
        bus.resp_s     <= core_s;
        bus.resp_c     <= core_c;
        bus.resp_v     <= core_v;
      end
      // Served requester loses priority.
      if (resp_done) begin
        bus.resp_valid <= 1'b0;
        rr_q           <= ~bus.resp_id;
      end
    end
  end

`ifdef OVF_CNT_EN
  // Saturating count of completed overflowing responses per requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt0 <= '0;
      ovf_cnt1 <= '0;
    end else if (resp_done && bus.resp_v) begin
      if (!bus.resp_id && (ovf_cnt0 != '1)) ovf_cnt0 <= ovf_cnt0 + CNT_W'(1);
      if (bus.resp_id && (ovf_cnt1 != '1))  ovf_cnt1 <= ovf_cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed steps plus random traffic
// against an arithmetic reference model. Define OVF_CNT_EN to also exercise
// the overflow counters.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_arbiter_if bus ();

`ifdef OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt0;
  logic [CNT_W-1:0] ovf_cnt1;
`endif

  addsub_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef OVF_CNT_EN
    ,
    .ovf_cnt0 (ovf_cnt0),
    .ovf_cnt1 (ovf_cnt1)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  logic model_rr;
  int   mcnt[2];
  time  t_grant;
  time  t_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: returns {s[2:0], c[2:0], v}.
  function automatic logic [6:0] ref_calc(input int a, input int b, input int m);
    int bb, sa, sb, r, sum;
    logic [2:0] c;
    bb  = (m != 0) ? (7 - b) : b;
    sum = (a + bb + m) % 8;
    for (int i = 0; i < 3; i++) begin
      c[i] = ((a % (2 << i)) + (bb % (2 << i)) + m) >= (2 << i);
    end
    sa = (a >= 4) ? a - 8 : a;
    sb = (b >= 4) ? b - 8 : b;
    r  = (m != 0) ? sa - sb : sa + sb;
    return {3'(sum), c, ((r > 3) || (r < -4)) ? 1'b1 : 1'b0};
  endfunction

  // One transaction from an IDLE cycle through response completion.
  task automatic txn(input bit v0, input int a0, input int b0, input int m0,
                     input bit v1, input int a1, input int b1, input int m1,
                     input int stall, input string tag);
    int gid;
    logic [6:0] e;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = 3'(a0); bus.req0_b = 3'(b0); bus.req0_m = 1'(m0);
    bus.req1_valid = v1; bus.req1_a = 3'(a1); bus.req1_b = 3'(b1); bus.req1_m = 1'(m1);
    bus.resp_ready = 1'b0;
    #1;
    gid = (v0 && v1) ? int'(model_rr) : (v1 ? 1 : 0);
    chk({tag, "_idle_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_ready0"}, 32'(bus.req0_ready), 32'(v0 && gid == 0));
    chk({tag, "_ready1"}, 32'(bus.req1_ready), 32'(v1 && gid == 1));
    if (!v0 && !v1) return;
    t_grant = $time;
    e = (gid == 1) ? ref_calc(a1, b1, m1) : ref_calc(a0, b0, m0);
    @(negedge clk);
    bus.req0_a = 3'($urandom); bus.req0_b = 3'($urandom); bus.req0_m = 1'($urandom);
    bus.req1_a = 3'($urandom); bus.req1_b = 3'($urandom); bus.req1_m = 1'($urandom);
    #1;
    chk({tag, "_calc_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_calc_rdy"}, 32'({bus.req0_ready, bus.req1_ready}), 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(bus.resp_valid), 1);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'(gid));
    chk({tag, "_s"}, 32'(bus.resp_s), 32'(e[6:4]));
    chk({tag, "_c"}, 32'(bus.resp_c), 32'(e[3:1]));
    chk({tag, "_v"}, 32'(bus.resp_v), 32'(e[0]));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      #1;
      chk({tag, "_stall_valid"}, 32'(bus.resp_valid), 1);
      chk({tag, "_stall_resp"}, 32'({bus.resp_id, bus.resp_s, bus.resp_c, bus.resp_v}),
          32'({1'(gid), e}));
      chk({tag, "_stall_rdy"}, 32'({bus.req0_ready, bus.req1_ready}), 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    model_rr = (gid == 0) ? 1'b1 : 1'b0;
    if (e[0] && mcnt[gid] < 255) mcnt[gid]++;
    #1;
    chk({tag, "_done_valid"}, 32'(bus.resp_valid), 0);
  endtask

  initial begin
    model_rr = 1'b0;
    mcnt[0]  = 0;
    mcnt[1]  = 0;
    t_grant  = 0;
    rst_n    = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd1; bus.req0_m = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 3'd2; bus.req1_b = 3'd2; bus.req1_m = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset values; readies held low while in reset even with valid requests.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
    chk("rst_resp", 32'({bus.resp_valid, bus.resp_id, bus.resp_s, bus.resp_c, bus.resp_v}), 0);
`ifdef OVF_CNT_EN
    chk("rst_cnt", 32'({ovf_cnt0, ovf_cnt1}), 0);
`endif
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Directed arithmetic.
    txn(1, 3, 2, 0, 0, 0, 0, 0, 0, "t1_add");
    txn(0, 0, 0, 0, 1, 3, 1, 1, 0, "t2_sub");
    txn(1, 0, 4, 1, 0, 0, 0, 0, 0, "sub_min");
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, "no_req");

    // Reset while an op is in CALC: discarded, rr pointer back to req0.
    txn(1, 7, 7, 0, 0, 0, 0, 0, 0, "pre_rst");
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 3'd2; bus.req1_b = 3'd3; bus.req1_m = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    chk("mid_grant1", 32'(bus.req1_ready), 1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(bus.resp_valid), 0);
    chk("mid_rst_idle_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    model_rr = 1'b0;
    mcnt[0]  = 0;
    mcnt[1]  = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mid_no_resp", 32'(bus.resp_valid), 0);
    end

    // Contention: alternating grants exactly 3 cycles apart.
    txn(1, 1, 2, 0, 1, 5, 6, 1, 0, "rr_a");
    for (int i = 0; i < 3; i++) begin
      t_prev = t_grant;
      txn(1, i, 3, 1, 1, 6, i, 0, 0, "rr_b");
      chk("rr_gap", 32'(t_grant - t_prev), 30);
    end

    // Back-pressure for 5 cycles.
    txn(1, 3, 3, 0, 1, 4, 4, 0, 5, "stall");

`ifdef OVF_CNT_EN
    chk("cnt0_pre", 32'(ovf_cnt0), 32'(mcnt[0]));
    chk("cnt1_pre", 32'(ovf_cnt1), 32'(mcnt[1]));
    for (int i = 0; i < 300; i++) txn(1, 4, 1, 1, 0, 0, 0, 0, 0, "sat");
    chk("cnt0_sat", 32'(ovf_cnt0), 255);
    chk("cnt1_sat", 32'(ovf_cnt1), 32'(mcnt[1]));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), "rand");
    end
`ifdef OVF_CNT_EN
    chk("cnt0_end", 32'(ovf_cnt0), 32'(mcnt[0]));
    chk("cnt1_end", 32'(ovf_cnt1), 32'(mcnt[1]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
